// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-core definitions used by the hazard/stall controller.
//   hazard_state_t : controller states (RUN, LOAD_STALL, MEM_WAIT)
//   REG_WORDS      : default number of architectural registers
//   reg_addr_t     : register-file address type sized from REG_WORDS
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_WORDS  = 32;
    localparam int REG_ADDR_W = $clog2(REG_WORDS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_stall_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_if
// Bundle between the s2-s4 pipeline and the hazard/stall controller.
//   master : pipeline side (drives hazard sources, receives hold/clear enables)
//   slave  : controller side
// Signals: valid_s2, r1/r2_addr_s2, r1/r2_used_s2, ld_s3, rw_s3, waddr_s3,
//          mem_req_s4, mem_ready_s4, flush  (pipeline -> controller)
//          stall_fe, bubble_s3, stall_all, mem_err, stall_cnt (controller -> pipeline)
// -----------------------------------------------------------------------------
interface hazard_stall_if #(
    parameter int ADDR_LEFT = $clog2(cpu_pkg::REG_WORDS) - 1,
    parameter int CNT_BITS  = 16
);
    logic                 valid_s2;
    logic [ADDR_LEFT:0]   r1_addr_s2;
    logic [ADDR_LEFT:0]   r2_addr_s2;
    logic                 r1_used_s2;
    logic                 r2_used_s2;
    logic                 ld_s3;
    logic                 rw_s3;
    logic [ADDR_LEFT:0]   waddr_s3;
    logic                 mem_req_s4;
    logic                 mem_ready_s4;
    logic                 flush;
    logic                 stall_fe;
    logic                 bubble_s3;
    logic                 stall_all;
    logic                 mem_err;
    logic [CNT_BITS-1:0]  stall_cnt;

    modport master (
        output valid_s2, r1_addr_s2, r2_addr_s2, r1_used_s2, r2_used_s2,
               ld_s3, rw_s3, waddr_s3, mem_req_s4, mem_ready_s4, flush,
        input  stall_fe, bubble_s3, stall_all, mem_err, stall_cnt
    );

    modport slave (
        input  valid_s2, r1_addr_s2, r2_addr_s2, r1_used_s2, r2_used_s2,
               ld_s3, rw_s3, waddr_s3, mem_req_s4, mem_ready_s4, flush,
        output stall_fe, bubble_s3, stall_all, mem_err, stall_cnt
    );

endinterface

// File: rtl/hazard_sat_cnt.sv
// -----------------------------------------------------------------------------
// hazard_sat_cnt
// Saturating up-counter with synchronous clear.
//   clk, rst_ : clock, asynchronous active-low reset
//   inc       : count up by one (holds at all-ones)
//   clr       : clear; clr together with inc loads 1
//   value     : current count
// -----------------------------------------------------------------------------
module hazard_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            // clear+inc restarts the count at the current cycle
            value_next = inc ? WIDTH'(1) : '0;
        end else if (inc && !(&value_reg)) begin
            value_next = value_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/hazard_stall.sv
// -----------------------------------------------------------------------------
// hazard_stall
// Stall side of operand forwarding: detects load-use hazards between s2/s3
// and data-memory wait states in s4, and drives the pipeline hold/clear enables.
//   clk, rst_      : pipeline clock, asynchronous active-low reset
//   bus (slave)    : hazard sources in, stall_fe / bubble_s3 / stall_all /
//                    mem_err / stall_cnt out (see hazard_stall_if)
// Hold/bubble outputs are combinational from state and inputs so the pipeline
// freezes in the same cycle the hazard is seen.
// -----------------------------------------------------------------------------
module hazard_stall
    import cpu_pkg::*;
#(
    parameter int REG_WORDS    = cpu_pkg::REG_WORDS,
    parameter int ADDR_LEFT    = $clog2(REG_WORDS) - 1,
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_BITS     = 16
) (
    input  logic          clk,
    input  logic          rst_,
    hazard_stall_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t      state_reg, state_next;
    logic [1:0]         bub_cnt_reg, bub_cnt_next;
    logic               mem_err_reg;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_inc, wait_clr;
    logic [ADDR_LEFT:0] waddr;
    logic               lu, mw, waiting, timeout, hold_all;
    logic               stall_fe_c, bubble_c, stall_inc;

    assign waddr = bus.waddr_s3;

    assign lu = bus.valid_s2 & bus.ld_s3 & bus.rw_s3 & (waddr != '0) &
                ((bus.r1_used_s2 & (bus.r1_addr_s2 == waddr)) |
                 (bus.r2_used_s2 & (bus.r2_addr_s2 == waddr)));

    assign mw       = bus.mem_req_s4 & ~bus.mem_ready_s4;
    assign waiting  = (state_reg == MEM_WAIT);
    // Wait counter holds the number of wait cycles already spent, so this is
    // the MEM_TIMEOUT-th consecutive cycle of the same access.
    assign timeout  = waiting & mw & (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign hold_all = mw & ~timeout;

    always_comb begin
        state_next   = state_reg;
        bub_cnt_next = bub_cnt_reg;
        stall_fe_c   = 1'b0;
        bubble_c     = 1'b0;
        wait_inc     = 1'b0;
        wait_clr     = 1'b0;
        if (hold_all) begin
            // Whole pipeline frozen; pending bubbles are kept untouched.
            wait_inc = 1'b1;
            if (!waiting) begin
                wait_clr   = 1'b1;
                state_next = MEM_WAIT;
            end
        end else begin
            if (waiting) begin
                wait_clr = 1'b1;
            end
            // On leaving MEM_WAIT the release cycle behaves like the state
            // being returned to, so no resumed bubble is lost.
            if (bub_cnt_reg != 2'd0) begin
                if (bus.flush) begin
                    bub_cnt_next = 2'd0;
                    state_next   = RUN;
                end else begin
                    stall_fe_c   = 1'b1;
                    bubble_c     = 1'b1;
                    bub_cnt_next = bub_cnt_reg - 2'd1;
                    state_next   = (bub_cnt_reg == 2'd1) ? RUN : LOAD_STALL;
                end
            end else begin
                state_next = RUN;
                if (!bus.flush && lu) begin
                    stall_fe_c = 1'b1;
                    bubble_c   = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_next   = LOAD_STALL;
                        bub_cnt_next = 2'(LOAD_BUBBLES - 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg   <= RUN;
            bub_cnt_reg <= 2'd0;
            mem_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bub_cnt_reg <= bub_cnt_next;
            if (timeout) begin
                mem_err_reg <= 1'b1;
            end
        end
    end

    hazard_sat_cnt #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_  (rst_),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .value (wait_cnt)
    );

    assign stall_inc = bus.stall_fe | bus.stall_all;

    hazard_sat_cnt #(.WIDTH(CNT_BITS)) u_stall_cnt (
        .clk   (clk),
        .rst_  (rst_),
        .inc   (stall_inc),
        .clr   (1'b0),
        .value (bus.stall_cnt)
    );

    // Enables are forced low for as long as reset is asserted.
    assign bus.stall_all = rst_ & hold_all;
    assign bus.stall_fe  = rst_ & stall_fe_c;
    assign bus.bubble_s3 = rst_ & bubble_c;
    assign bus.mem_err   = mem_err_reg;

endmodule

// File: tb/tb_hazard_stall.sv
module tb_hazard_stall;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    logic       valid_s2, r1_used_s2, r2_used_s2, ld_s3, rw_s3;
    logic       mem_req_s4, mem_ready_s4, flush;
    logic [4:0] r1_addr_s2, r2_addr_s2, waddr_s3;

    int nvec = 0;
    int nerr = 0;

    // A: LOAD_BUBBLES=1, MEM_TIMEOUT=255, CNT_BITS=16
    // B: LOAD_BUBBLES=2, MEM_TIMEOUT=4,   CNT_BITS=4
    hazard_stall_if #(.ADDR_LEFT(4), .CNT_BITS(16)) if_a ();
    hazard_stall_if #(.ADDR_LEFT(4), .CNT_BITS(4))  if_b ();

    assign if_a.valid_s2 = valid_s2;     assign if_b.valid_s2 = valid_s2;
    assign if_a.r1_addr_s2 = r1_addr_s2; assign if_b.r1_addr_s2 = r1_addr_s2;
    assign if_a.r2_addr_s2 = r2_addr_s2; assign if_b.r2_addr_s2 = r2_addr_s2;
    assign if_a.r1_used_s2 = r1_used_s2; assign if_b.r1_used_s2 = r1_used_s2;
    assign if_a.r2_used_s2 = r2_used_s2; assign if_b.r2_used_s2 = r2_used_s2;
    assign if_a.ld_s3 = ld_s3;           assign if_b.ld_s3 = ld_s3;
    assign if_a.rw_s3 = rw_s3;           assign if_b.rw_s3 = rw_s3;
    assign if_a.waddr_s3 = waddr_s3;     assign if_b.waddr_s3 = waddr_s3;
    assign if_a.mem_req_s4 = mem_req_s4; assign if_b.mem_req_s4 = mem_req_s4;
    assign if_a.mem_ready_s4 = mem_ready_s4; assign if_b.mem_ready_s4 = mem_ready_s4;
    assign if_a.flush = flush;           assign if_b.flush = flush;

    hazard_stall #(.REG_WORDS(32), .ADDR_LEFT(4), .LOAD_BUBBLES(1),
                   .MEM_TIMEOUT(255), .CNT_BITS(16)) dut_a (
        .clk(clk), .rst_(rst_), .bus(if_a));
    hazard_stall #(.REG_WORDS(32), .ADDR_LEFT(4), .LOAD_BUBBLES(2),
                   .MEM_TIMEOUT(4), .CNT_BITS(4)) dut_b (
        .clk(clk), .rst_(rst_), .bus(if_b));

    // ---------------- reference model (per configuration c) ----------------
    int m_pend[2];   // bubbles still owed to the current load-use hazard
    int m_wait[2];   // wait cycles already spent on the current memory access
    int m_cnt[2];
    bit m_err[2];

    function automatic int lb_of(int c);   return (c == 0) ? 1 : 2;       endfunction
    function automatic int to_of(int c);   return (c == 0) ? 255 : 4;     endfunction
    function automatic int cmax_of(int c); return (c == 0) ? 65535 : 15;  endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0; m_wait[c] = 0; m_cnt[c] = 0; m_err[c] = 1'b0;
        end
    endfunction

    // Returns {stall_fe, bubble_s3, stall_all, mem_err, stall_cnt[15:0]} for
    // this cycle and advances the model by one clock.
    function automatic logic [19:0] model_cycle(int c);
        bit lu_h, mw_h, tmo, fe, all;
        logic [19:0] e;
        lu_h = valid_s2 && ld_s3 && rw_s3 && (waddr_s3 != 0) &&
               ((r1_used_s2 && r1_addr_s2 == waddr_s3) || (r2_used_s2 && r2_addr_s2 == waddr_s3));
        mw_h = mem_req_s4 && !mem_ready_s4;
        tmo  = mw_h && (m_wait[c] == to_of(c) - 1);
        all  = mw_h && !tmo;
        fe   = 1'b0;
        e[16]   = m_err[c];
        e[15:0] = 16'(m_cnt[c]);
        if (all) begin
            m_wait[c] = m_wait[c] + 1;
        end else begin
            m_wait[c] = 0;
            if (tmo) m_err[c] = 1'b1;
            if (m_pend[c] > 0) begin
                if (flush) m_pend[c] = 0;
                else begin fe = 1'b1; m_pend[c] = m_pend[c] - 1; end
            end else if (!flush && lu_h) begin
                fe = 1'b1;
                m_pend[c] = lb_of(c) - 1;
            end
        end
        if ((fe || all) && m_cnt[c] < cmax_of(c)) m_cnt[c] = m_cnt[c] + 1;
        e[19] = fe; e[18] = fe; e[17] = all;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        valid_s2 = 0; r1_used_s2 = 0; r2_used_s2 = 0; ld_s3 = 0; rw_s3 = 0;
        mem_req_s4 = 0; mem_ready_s4 = 0; flush = 0;
        r1_addr_s2 = 0; r2_addr_s2 = 0; waddr_s3 = 0;
    endtask

    task automatic set_lu(input logic [4:0] wa, input logic [4:0] src);
        valid_s2 = 1; ld_s3 = 1; rw_s3 = 1; waddr_s3 = wa;
        r2_addr_s2 = src; r2_used_s2 = 1; r1_used_s2 = 0; r1_addr_s2 = 5'd31;
    endtask

    task automatic do_reset();
        rst_ = 0;
        idle();
        model_reset();
        @(negedge clk);
        rst_ = 1;
    endtask

    // Called just after a falling edge with inputs set; samples the DUTs,
    // runs the model and returns at the next falling edge.
    task automatic step(output logic [19:0] oa, output logic [19:0] ea,
                        output logic [19:0] ob, output logic [19:0] eb);
        #1;
        oa = {if_a.stall_fe, if_a.bubble_s3, if_a.stall_all, if_a.mem_err, if_a.stall_cnt};
        ob = {if_b.stall_fe, if_b.bubble_s3, if_b.stall_all, if_b.mem_err, 12'd0, if_b.stall_cnt};
        ea = model_cycle(0);
        eb = model_cycle(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [19:0] oa, ea, ob, eb;
        rst_ = 0; idle(); model_reset();
        set_lu(5'd5, 5'd5);
        #1;
        nvec++;
        if ({if_a.stall_fe, if_a.bubble_s3, if_a.stall_all, if_a.mem_err, if_a.stall_cnt,
             if_b.stall_fe, if_b.bubble_s3, if_b.stall_all, if_b.mem_err, if_b.stall_cnt} !== 28'd0) begin
            $display("FAIL reset_state: got a_fe=%b b_fe=%b a_cnt=%0d b_cnt=%0d want all 0",
                     if_a.stall_fe, if_b.stall_fe, if_a.stall_cnt, if_b.stall_cnt);
            nerr++;
        end
        @(negedge clk); rst_ = 1;
        step(oa, ea, ob, eb);                  // B enters LOAD_STALL
        nvec++; if (ob !== eb) begin $display("FAIL reset_pre_b: got %h want %h", ob, eb); nerr++; end
        #1;
        nvec++; if (if_b.stall_fe !== 1'b1) begin
            $display("FAIL reset_bubble2_b: got stall_fe=%b want 1", if_b.stall_fe); nerr++; end
        rst_ = 0;                              // asynchronous, mid-cycle
        #1;
        nvec++;
        if ({if_b.stall_fe, if_b.bubble_s3, if_b.stall_all, if_b.stall_cnt, if_a.stall_cnt} !== 23'd0) begin
            $display("FAIL reset_async: got b_fe=%b b_bub=%b b_cnt=%0d a_cnt=%0d want 0",
                     if_b.stall_fe, if_b.bubble_s3, if_b.stall_cnt, if_a.stall_cnt);
            nerr++;
        end
        model_reset();
        @(negedge clk); rst_ = 1; idle();
        step(oa, ea, ob, eb);
        nvec++; if (ob !== eb) begin $display("FAIL reset_release_b: got %h want %h", ob, eb); nerr++; end
        set_lu(5'd5, 5'd5);
        step(oa, ea, ob, eb);
        nvec++; if (oa !== ea) begin $display("FAIL reset_run_a: got %h want %h", oa, ea); nerr++; end
        nvec++; if (ob !== eb) begin $display("FAIL reset_run_b: got %h want %h", ob, eb); nerr++; end
        idle();
        step(oa, ea, ob, eb);
    endtask

    task automatic test_load_use();
        logic [19:0] oa, ea, ob, eb;
        int b_bubbles = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i == 0) set_lu(5'd5, 5'd5);
            if (i == 3) set_lu(5'd0, 5'd0);
            if (i == 4) begin
                set_lu(5'd7, 5'd7); r1_addr_s2 = 5'd7; r1_used_s2 = 1;
            end
            step(oa, ea, ob, eb);
            nvec++; if (oa !== ea) begin $display("FAIL lu_a cyc%0d: got %h want %h", i, oa, ea); nerr++; end
            nvec++; if (ob !== eb) begin $display("FAIL lu_b cyc%0d: got %h want %h", i, ob, eb); nerr++; end
            if (i >= 4) b_bubbles += int'(ob[18]);
            if (i == 0 || i == 1 || i == 3) begin
                nvec++;
                if (oa[19] !== (i == 0)) begin
                    $display("FAIL lu_single_a cyc%0d: got stall_fe=%b want %b", i, oa[19], (i == 0)); nerr++;
                end
            end
            if (i == 3) begin
                nvec++; if (ob[19] !== 1'b0) begin
                    $display("FAIL lu_zero_b: got stall_fe=%b want 0", ob[19]); nerr++; end
            end
        end
        nvec++; if (b_bubbles !== 2) begin
            $display("FAIL lu_both_src_b: got %0d bubbles want 2", b_bubbles); nerr++; end
    endtask

    task automatic test_mem_bubble();
        logic [19:0] oa, ea, ob, eb;
        int b_all = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) set_lu(5'd9, 5'd9);
            if (i >= 1 && i <= 4) begin mem_req_s4 = 1; mem_ready_s4 = (i == 4); end
            step(oa, ea, ob, eb);
            nvec++; if (oa !== ea) begin $display("FAIL membub_a cyc%0d: got %h want %h", i, oa, ea); nerr++; end
            nvec++; if (ob !== eb) begin $display("FAIL membub_b cyc%0d: got %h want %h", i, ob, eb); nerr++; end
            b_all += int'(ob[17]);
        end
        nvec++; if (b_all !== 3) begin $display("FAIL membub_all_b: got %0d cycles want 3", b_all); nerr++; end
        nvec++; if (if_b.stall_cnt !== 4'd5) begin
            $display("FAIL membub_cnt_b: got %0d want 5", if_b.stall_cnt); nerr++; end
    endtask

    task automatic test_flush();
        logic [19:0] oa, ea, ob, eb;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i <= 1) set_lu(5'd3, 5'd3);
            if (i == 0 || i == 2) flush = 1;
            step(oa, ea, ob, eb);
            nvec++; if (oa !== ea) begin $display("FAIL flush_a cyc%0d: got %h want %h", i, oa, ea); nerr++; end
            nvec++; if (ob !== eb) begin $display("FAIL flush_b cyc%0d: got %h want %h", i, ob, eb); nerr++; end
            if (i != 1) begin
                nvec++; if ({oa[19], ob[19]} !== 2'b00) begin
                    $display("FAIL flush_nostall cyc%0d: got a=%b b=%b want 0", i, oa[19], ob[19]); nerr++; end
            end
        end
    endtask

    task automatic test_timeout();
        logic [19:0] oa, ea, ob, eb;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            idle();
            if (i < 12) mem_req_s4 = 1;
            step(oa, ea, ob, eb);
            nvec++; if (oa !== ea) begin $display("FAIL tmo_a cyc%0d: got %h want %h", i, oa, ea); nerr++; end
            nvec++; if (ob !== eb) begin $display("FAIL tmo_b cyc%0d: got %h want %h", i, ob, eb); nerr++; end
            if (i < 4) begin
                nvec++; if (ob[17] !== (i != 3)) begin
                    $display("FAIL tmo_pattern_b cyc%0d: got stall_all=%b want %b", i, ob[17], (i != 3)); nerr++; end
            end
        end
        nvec++; if ({if_b.mem_err, if_a.mem_err} !== 2'b10) begin
            $display("FAIL tmo_err: got b=%b a=%b want b=1 a=0", if_b.mem_err, if_a.mem_err); nerr++; end
    endtask

    task automatic test_saturate();
        logic [19:0] oa, ea, ob, eb;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            idle();
            mem_req_s4 = 1;
            step(oa, ea, ob, eb);
            nvec++; if (oa !== ea) begin $display("FAIL sat_a cyc%0d: got %h want %h", i, oa, ea); nerr++; end
            nvec++; if (ob !== eb) begin $display("FAIL sat_b cyc%0d: got %h want %h", i, ob, eb); nerr++; end
            if (i == 19 || i == 23) begin
                nvec++; if (if_b.stall_cnt !== 4'd15) begin
                    $display("FAIL sat_hold_b cyc%0d: got %0d want 15", i, if_b.stall_cnt); nerr++; end
            end
        end
        nvec++; if (if_a.stall_cnt !== 16'd24) begin
            $display("FAIL sat_count_a: got %0d want 24", if_a.stall_cnt); nerr++; end
    endtask

    task automatic test_random();
        logic [19:0] oa, ea, ob, eb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid_s2     = ($urandom_range(0, 7) != 0);
            r1_addr_s2   = 5'($urandom_range(0, 3));
            r2_addr_s2   = 5'($urandom_range(0, 3));
            r1_used_s2   = 1'($urandom);
            r2_used_s2   = 1'($urandom);
            ld_s3        = ($urandom_range(0, 3) != 0);
            rw_s3        = ($urandom_range(0, 7) != 0);
            waddr_s3     = 5'($urandom_range(0, 3));
            mem_req_s4   = ($urandom_range(0, 3) == 0);
            mem_ready_s4 = 1'($urandom);
            flush        = ($urandom_range(0, 7) == 0);
            step(oa, ea, ob, eb);
            nvec++; if (oa !== ea) begin $display("FAIL rand_a cyc%0d: got %h want %h", i, oa, ea); nerr++; end
            nvec++; if (ob !== eb) begin $display("FAIL rand_b cyc%0d: got %h want %h", i, ob, eb); nerr++; end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_bubble();
        test_flush();
        test_timeout();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
